// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg
//   Shared definitions for the performance-counter Avalon-MM master:
//   - command opcodes
//   - the register map of one counter section
//   - the master FSM state type
//   - an address helper used by the top level
package perf_counter_pkg;

  typedef enum logic [1:0] {
    OP_START     = 2'd0,
    OP_STOP      = 2'd1,
    OP_RESET_ALL = 2'd2,
    OP_SNAPSHOT  = 2'd3
  } op_e;

  // Each section owns four consecutive word addresses.
  localparam int SECTION_STRIDE = 4;

  // Offsets within a section.
  // On write, the same offset acts as a control: offset 0 is STOP, offset 1 is GO.
  // On read, it returns data: offset 0 is the time LO word, offset 1 is time HI.
  localparam logic [1:0] OFF_STOP_TLO = 2'd0;
  localparam logic [1:0] OFF_GO_THI   = 2'd1;
  localparam logic [1:0] OFF_EVT      = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_HI1,
    S_RD_LO,
    S_RD_HI2,
    S_RD_EV,
    S_EMIT
  } state_e;

  // Word address of (section, offset).
  // The stride is 4, so the address is just the concatenation.
  function automatic logic [4:0] sec_addr(input logic [2:0] sec, input logic [1:0] off);
    return {sec, off};
  endfunction

endpackage

// File: rtl/perf_counter_master_avm_single_xfer.sv
// avm_single_xfer
//   Issues one Avalon-MM read or write per i_start pulse and reports completion.
//
//   Handshake: a request (read or write) is accepted in a cycle where it is high
//   and i_avm_waitrequest is 0. Address, data and the read/write strobe are held
//   constant until that cycle, then dropped on the next cycle. begintransfer is
//   high only in the first request cycle, even if that cycle is stalled.
//
//   Completion:
//   - A write completes in its acceptance cycle.
//   - A read completes exactly READ_LATENCY cycles after acceptance; o_rdata
//     carries the slave data during the o_done cycle.
//   - i_start may be asserted in the o_done cycle of a read to chain transfers.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   i_start                  launch a transfer (only when no transfer is active)
//   i_read                   1 = read, 0 = write
//   i_addr, i_wdata          transfer address / write data
//   o_avm_*                  Avalon-MM request signals
//   i_avm_readdata           slave read data
//   i_avm_waitrequest        slave stall
//   o_done                   one-cycle completion pulse
//   o_rdata                  read data, valid with o_done for reads
module perf_counter_master_avm_single_xfer #(
  parameter int ADDR_W       = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_read,
  output logic              o_avm_write,
  output logic              o_avm_begintransfer,
  output logic [31:0]       o_avm_writedata,
  input  logic [31:0]       i_avm_readdata,
  input  logic              i_avm_waitrequest,
  output logic              o_done,
  output logic [31:0]       o_rdata
);

  logic              r_req;
  logic              r_first;
  logic              r_is_read;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_pend;
  logic [7:0]        r_cnt;

  logic w_accept;
  logic w_rd_done;

  assign w_accept  = r_req & ~i_avm_waitrequest;
  assign w_rd_done = r_pend & (r_cnt == 8'(READ_LATENCY));

  assign o_done  = (w_accept & ~r_is_read) | w_rd_done;
  assign o_rdata = i_avm_readdata;

  assign o_avm_address       = r_addr;
  assign o_avm_writedata     = r_wdata;
  assign o_avm_read          = r_req & r_is_read;
  assign o_avm_write         = r_req & ~r_is_read;
  assign o_avm_begintransfer = r_req & r_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req     <= 1'b0;
      r_first   <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_req) r_first <= 1'b0;
      if (w_accept) r_req <= 1'b0;

      // Count cycles since read acceptance.
      // Data is taken when the count reaches READ_LATENCY.
      if (w_accept && r_is_read) begin
        r_pend <= 1'b1;
        r_cnt  <= 8'd1;
      end else if (w_rd_done) begin
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (i_start) begin
        r_req     <= 1'b1;
        r_first   <= 1'b1;
        r_is_read <= i_read;
        r_addr    <= i_addr;
        r_wdata   <= i_read ? 32'd0 : i_wdata;
      end
    end
  end

endmodule

// File: rtl/perf_counter_master.sv
// perf_counter_master
//   Avalon-MM master for the 8-section performance counter slave.
//
//   Commands:
//   - START / STOP / RESET_ALL become single writes.
//   - SNAPSHOT reads every section and streams one record per section.
//
//   Snapshot time coherence: each section's time is read HI, then LO, then HI
//   again. If the high word moved between the two HI reads, the low word is
//   re-read until the high word is stable.
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_section command handshake
//                                          (accepted only when idle)
//   busy                                  FSM not idle
//   avm_*                                 Avalon-MM master interface
//   snap_valid/snap_ready                 snapshot record handshake
//   snap_section/snap_time/snap_events    snapshot record fields
//                                          (held stable while stalled)
module perf_counter_master
  import perf_counter_pkg::*;
#(
  parameter int NUM_SECTIONS = 8,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_section,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic              avm_begintransfer,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [2:0]        snap_section,
  output logic [63:0]       snap_time,
  output logic [31:0]       snap_events
);

  localparam logic [3:0] NUM_SEC_L = 4'(NUM_SECTIONS);
  localparam logic [2:0] LAST_SEC  = 3'(NUM_SECTIONS - 1);

  state_e      r_state;
  state_e      w_next;
  logic [2:0]  r_section;
  logic [31:0] r_hi1;
  logic [31:0] r_lo;
  logic [31:0] r_hi2;
  logic [31:0] r_ev;

  logic        w_start;
  logic        w_read;
  logic [2:0]  w_sec;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_last;
  logic        w_sec_ok;

  assign w_last   = (r_section == LAST_SEC);
  assign w_sec_ok = ({1'b0, cmd_section} < NUM_SEC_L);

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign snap_valid   = (r_state == S_EMIT);
  assign snap_section = r_section;
  assign snap_time    = {r_hi2, r_lo};
  assign snap_events  = r_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. Each bus transfer is launched on the transition into its
  // state, so the request appears in the first cycle of that state.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_read  = 1'b0;
    w_sec   = r_section;
    w_off   = OFF_STOP_TLO;
    w_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_START, OP_STOP: begin
              // Out-of-range sections are accepted but produce no bus traffic.
              if (w_sec_ok) begin
                w_start = 1'b1;
                w_sec   = cmd_section;
                w_off   = (op_e'(cmd_op) == OP_START) ? OFF_GO_THI : OFF_STOP_TLO;
                w_next  = S_WR;
              end
            end
            OP_RESET_ALL: begin
              w_start = 1'b1;
              w_sec   = 3'd0;
              w_off   = OFF_STOP_TLO;
              w_wdata = 32'd1;
              w_next  = S_WR;
            end
            default: begin
              w_start = 1'b1;
              w_read  = 1'b1;
              w_sec   = 3'd0;
              w_off   = OFF_GO_THI;
              w_next  = S_RD_HI1;
            end
          endcase
        end
      end
      S_WR: begin
        if (w_done) w_next = S_IDLE;
      end
      S_RD_HI1: begin
        if (w_done) begin
          w_start = 1'b1;
          w_read  = 1'b1;
          w_off   = OFF_STOP_TLO;
          w_next  = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (w_done) begin
          w_start = 1'b1;
          w_read  = 1'b1;
          w_off   = OFF_GO_THI;
          w_next  = S_RD_HI2;
        end
      end
      S_RD_HI2: begin
        if (w_done) begin
          w_start = 1'b1;
          w_read  = 1'b1;
          // High word moved: the LO already read may belong to the old HI,
          // so read LO again.
          if (w_rdata != r_hi1) begin
            w_off  = OFF_STOP_TLO;
            w_next = S_RD_LO;
          end else begin
            w_off  = OFF_EVT;
            w_next = S_RD_EV;
          end
        end
      end
      S_RD_EV: begin
        if (w_done) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (snap_ready) begin
          if (w_last) begin
            w_next = S_IDLE;
          end else begin
            w_start = 1'b1;
            w_read  = 1'b1;
            w_sec   = r_section + 3'd1;
            w_off   = OFF_GO_THI;
            w_next  = S_RD_HI1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_section <= '0;
      r_hi1     <= '0;
      r_lo      <= '0;
      r_hi2     <= '0;
      r_ev      <= '0;
    end else begin
      if (r_state == S_RD_HI1 && w_done) r_hi1 <= w_rdata;
      if (r_state == S_RD_LO  && w_done) r_lo  <= w_rdata;
      // The second HI read also becomes the reference for a retry.
      if (r_state == S_RD_HI2 && w_done) begin
        r_hi2 <= w_rdata;
        r_hi1 <= w_rdata;
      end
      if (r_state == S_RD_EV && w_done) r_ev <= w_rdata;
      if (r_state == S_EMIT && snap_ready) r_section <= w_last ? 3'd0 : r_section + 3'd1;
    end
  end

  perf_counter_master_avm_single_xfer #(
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_xfer (
    .clk                 (clk),
    .reset_n             (reset_n),
    .i_start             (w_start),
    .i_read              (w_read),
    .i_addr              (ADDR_W'(sec_addr(w_sec, w_off))),
    .i_wdata             (w_wdata),
    .o_avm_address       (avm_address),
    .o_avm_read          (avm_read),
    .o_avm_write         (avm_write),
    .o_avm_begintransfer (avm_begintransfer),
    .o_avm_writedata     (avm_writedata),
    .i_avm_readdata      (avm_readdata),
    .i_avm_waitrequest   (avm_waitrequest),
    .o_done              (w_done),
    .o_rdata             (w_rdata)
  );

endmodule

// File: tb/tb_perf_counter_master.sv
// Directed bench for perf_counter_master with a small Avalon-MM slave model.
// A second instance with NUM_SECTIONS=4 exercises out-of-range START/STOP.
module tb_perf_counter_master;
  import perf_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_valid4;
  logic        cmd_ready, cmd_ready4;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_section;
  logic        busy, busy4;
  logic [4:0]  avm_address, avm_address4;
  logic        avm_read, avm_read4, avm_write, avm_write4;
  logic        avm_begintransfer, avm_begintransfer4;
  logic [31:0] avm_writedata, avm_writedata4;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest;
  logic        snap_valid, snap_valid4, snap_ready;
  logic [2:0]  snap_section, snap_section4;
  logic [63:0] snap_time, snap_time4;
  logic [31:0] snap_events, snap_events4;

  always #5 clk = ~clk;

  perf_counter_master #(.NUM_SECTIONS(8), .READ_LATENCY(1), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_section(cmd_section), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_begintransfer(avm_begintransfer), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_section(snap_section),
    .snap_time(snap_time), .snap_events(snap_events)
  );

  perf_counter_master #(.NUM_SECTIONS(4), .READ_LATENCY(1), .ADDR_W(5)) dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_section(cmd_section), .busy(busy4),
    .avm_address(avm_address4), .avm_read(avm_read4), .avm_write(avm_write4),
    .avm_begintransfer(avm_begintransfer4), .avm_writedata(avm_writedata4),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .snap_valid(snap_valid4), .snap_ready(snap_ready), .snap_section(snap_section4),
    .snap_time(snap_time4), .snap_events(snap_events4)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:31];
  logic        race_mode;
  int          hi_cnt = 0;
  int          lo_cnt = 0;

  function automatic logic [31:0] m_hi(int s);
    return (s == 1) ? 32'h5 : 32'(32'hA0 + s);
  endfunction
  function automatic logic [31:0] m_lo(int s);
    return (s == 1) ? 32'h1234_5678 : 32'(32'hC0DE_0000 + s);
  endfunction
  function automatic logic [31:0] m_ev(int s);
    return (s == 1) ? 32'd7 : 32'(100 + s);
  endfunction

  // Registered read data: valid one cycle after acceptance (READ_LATENCY=1).
  // In race mode section 0's HI reads return 4,5,5,... and LO reads return 1,3,...
  always @(posedge clk) begin
    if (!race_mode) begin
      hi_cnt <= 0;
      lo_cnt <= 0;
    end
    if (avm_read && !avm_waitrequest) begin
      if (race_mode && avm_address == 5'd1) begin
        avm_readdata <= (hi_cnt == 0) ? 32'h4 : 32'h5;
        hi_cnt <= hi_cnt + 1;
      end else if (race_mode && avm_address == 5'd0) begin
        avm_readdata <= (lo_cnt == 0) ? 32'h1 : 32'h3;
        lo_cnt <= lo_cnt + 1;
      end else begin
        avm_readdata <= mem[avm_address];
      end
    end
  end

  // ---------------- bus / record monitor ----------------
  int wr_acc = 0, wr_cycles = 0, bt_cycles = 0, rd_acc = 0, dut4_traffic = 0;
  logic [2:0]  rec_sec_q[$];
  logic [63:0] rec_time_q[$];
  logic [31:0] rec_ev_q[$];

  always @(negedge clk) begin
    if (avm_write) wr_cycles++;
    if (avm_write && !avm_waitrequest) wr_acc++;
    if (avm_begintransfer) bt_cycles++;
    if (avm_read && !avm_waitrequest) rd_acc++;
    if (avm_write4 || avm_read4) dut4_traffic++;
    if (snap_valid && snap_ready) begin
      rec_sec_q.push_back(snap_section);
      rec_time_q.push_back(snap_time);
      rec_ev_q.push_back(snap_events);
    end
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0]  exp_sec_q[$];
  logic [63:0] exp_time_q[$];
  logic [31:0] exp_ev_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_rd"}, 64'(avm_read), 64'd0);
    chk({tag, "_wr"}, 64'(avm_write), 64'd0);
    chk({tag, "_bt"}, 64'(avm_begintransfer), 64'd0);
    chk({tag, "_wdata"}, 64'(avm_writedata), 64'd0);
    chk({tag, "_svalid"}, 64'(snap_valid), 64'd0);
    chk({tag, "_ssec"}, 64'(snap_section), 64'd0);
    chk({tag, "_stime"}, snap_time, 64'd0);
    chk({tag, "_sev"}, 64'(snap_events), 64'd0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    cyc();
  endtask

  task automatic compare_records(input string tag);
    chk({tag, "_count"}, 64'(rec_sec_q.size()), 64'(exp_sec_q.size()));
    while (exp_sec_q.size() > 0 && rec_sec_q.size() > 0) begin
      chk({tag, "_sec"}, 64'(rec_sec_q.pop_front()), 64'(exp_sec_q.pop_front()));
      chk({tag, "_time"}, rec_time_q.pop_front(), exp_time_q.pop_front());
      chk({tag, "_ev"}, 64'(rec_ev_q.pop_front()), 64'(exp_ev_q.pop_front()));
    end
    exp_sec_q.delete(); exp_time_q.delete(); exp_ev_q.delete();
    rec_sec_q.delete(); rec_time_q.delete(); rec_ev_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_valid4 = 1'b0; cmd_op = 2'd0; cmd_section = 3'd0;
    avm_waitrequest = 1'b0; snap_ready = 1'b1; race_mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      mem[4*s]   = m_lo(s);
      mem[4*s+1] = m_hi(s);
      mem[4*s+2] = m_ev(s);
      mem[4*s+3] = 32'd0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    cyc(); reset_n = 1'b1;
    cyc();

    // 1. START 2: one write to address 9, data 0
    base = wr_acc;
    cmd_valid = 1'b1; cmd_op = OP_START; cmd_section = 3'd2;
    @(negedge clk); chk("t1_cmd_ready_accept", 64'(cmd_ready), 64'd1);
    cyc(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_wr", 64'(avm_write), 64'd1);
    chk("t1_addr", 64'(avm_address), 64'd9);
    chk("t1_wdata", 64'(avm_writedata), 64'd0);
    chk("t1_bt", 64'(avm_begintransfer), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    cyc(); @(negedge clk);
    chk("t1_wr_drop", 64'(avm_write), 64'd0);
    chk("t1_cmd_ready_back", 64'(cmd_ready), 64'd1);
    cyc();
    chk("t1_wr_count", 64'(wr_acc - base), 64'd1);

    // 2. STOP 3 with waitrequest high for 4 request cycles
    base = wr_acc; base2 = bt_cycles;
    cmd_valid = 1'b1; cmd_op = OP_STOP; cmd_section = 3'd3; avm_waitrequest = 1'b1;
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("t2_wr_held", 64'(avm_write), 64'd1);
      chk("t2_addr_held", 64'(avm_address), 64'd12);
      chk("t2_bt", 64'(avm_begintransfer), 64'(i == 0));
      cyc();
    end
    @(negedge clk);
    chk("t2_wr_drop", 64'(avm_write), 64'd0);
    chk("t2_cmd_ready_back", 64'(cmd_ready), 64'd1);
    cyc();
    chk("t2_wr_count", 64'(wr_acc - base), 64'd1);
    chk("t2_bt_count", 64'(bt_cycles - base2), 64'd1);

    // 3. RESET_ALL: write address 0, data 1
    cmd_valid = 1'b1; cmd_op = OP_RESET_ALL; cmd_section = 3'd5;
    cyc(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_wr", 64'(avm_write), 64'd1);
    chk("t3_addr", 64'(avm_address), 64'd0);
    chk("t3_wdata", 64'(avm_writedata), 64'd1);
    cyc(); @(negedge clk);
    chk("t3_cmd_ready_back", 64'(cmd_ready), 64'd1);
    cyc();
    // Out-of-range START 5 / STOP 7 on the 4-section instance
    cmd_valid4 = 1'b1; cmd_op = OP_START; cmd_section = 3'd5;
    @(negedge clk); chk("t3_oor_ready", 64'(cmd_ready4), 64'd1);
    cyc(); cmd_op = OP_STOP; cmd_section = 3'd7;
    @(negedge clk);
    chk("t3_oor_busy", 64'(busy4), 64'd0);
    chk("t3_oor_ready2", 64'(cmd_ready4), 64'd1);
    cyc(); cmd_valid4 = 1'b0;
    repeat (3) cyc();
    chk("t3_oor_traffic", 64'(dut4_traffic), 64'd0);

    // 4. Full snapshot, 8 records in section order
    base = rd_acc;
    for (int s = 0; s < 8; s++) begin
      exp_sec_q.push_back(3'(s));
      exp_time_q.push_back({m_hi(s), m_lo(s)});
      exp_ev_q.push_back(m_ev(s));
    end
    cmd_valid = 1'b1; cmd_op = OP_SNAPSHOT;
    cyc(); cmd_valid = 1'b0;
    wait_idle(500);
    cyc();
    chk("t4_reads", 64'(rd_acc - base), 64'd32);
    compare_records("t4");

    // 5. Carry race on section 0: HI 4 -> 5, LO re-read as 3
    base = rd_acc;
    race_mode = 1'b1;
    exp_sec_q.push_back(3'd0);
    exp_time_q.push_back(64'h5_0000_0003);
    exp_ev_q.push_back(m_ev(0));
    for (int s = 1; s < 8; s++) begin
      exp_sec_q.push_back(3'(s));
      exp_time_q.push_back({m_hi(s), m_lo(s)});
      exp_ev_q.push_back(m_ev(s));
    end
    cmd_valid = 1'b1; cmd_op = OP_SNAPSHOT;
    cyc(); cmd_valid = 1'b0;
    wait_idle(500);
    cyc();
    race_mode = 1'b0;
    chk("t5_reads", 64'(rd_acc - base), 64'd34);
    chk("t5_lo_reads", 64'(lo_cnt), 64'd2);
    compare_records("t5");

    // 6. Backpressure then reset mid-snapshot
    snap_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_SNAPSHOT;
    cyc(); cmd_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!snap_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_valid_timeout", 64'(snap_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(); @(negedge clk);
      chk("t6_stall_valid", 64'(snap_valid), 64'd1);
      chk("t6_stall_sec", 64'(snap_section), 64'd0);
      chk("t6_stall_time", snap_time, {m_hi(0), m_lo(0)});
      chk("t6_stall_ev", 64'(snap_events), 64'(m_ev(0)));
      chk("t6_stall_no_read", 64'(avm_read), 64'd0);
    end
    cyc(); reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    cyc(); reset_n = 1'b1; snap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_post_valid", 64'(snap_valid), 64'd0);
      chk("t6_post_busy", 64'(busy), 64'd0);
      cyc();
    end
    chk("t6_no_record", 64'(rec_sec_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
